wb_spi_slave: RTL and testbench



---
 rtl/wb_spi_slave_pkg.sv | 15 +
 rtl/wb_spi_slave_fifo.sv | 40 ++++
 rtl/wb_spi_slave.sv | 151 +++++++++++++++
 tb/tb_wb_spi_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_slave_pkg.sv
// wb_spi_slave_pkg: register map, STATUS/CTRL bit positions and FSM states for wb_spi_slave
package wb_spi_slave_pkg;
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_OVERRUN  = 3;
    localparam int ST_BUSY     = 4;
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;
endpackage

// File: rtl/wb_spi_slave_fifo.sv
// wb_spi_slave_fifo: 8-bit synchronous RX FIFO; push on full is accepted only alongside a pop
module wb_spi_slave_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q];
    // storage array, no reset needed since reads are gated by the count
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/wb_spi_slave.sv
// wb_spi_slave: Wishbone SPI mode-0 target with RX FIFO and TX holding register; SPI_SLAVE_IRQ_EN adds intr/irq_en
module wb_spi_slave import wb_spi_slave_pkg::*; #(
    parameter int         RX_DEPTH   = 16,
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        intr
);
    logic [2:0] sck_q, mosi_q, cs_q;
    state_e state_q;
    logic [2:0] bitcnt_q;
    logic [7:0] tx_sh_q, rx_sh_q, tx_q;
    logic [31:0] dat_q;
    logic miso_q, oe_q, ack_q, tx_empty_q, overrun_q, enable_q, irq_en;
    logic sck_rise, sck_fall, cs_fall, cs_rise, abort, tx_load, rx_push;
    logic wb_hit, wr, rd, rx_pop, rx_full, rx_empty, overflow;
    logic [7:0] load_byte, rx_byte, rx_head;
    logic [1:0] adr;
    logic [4:0] status;
    logic [31:0] rd_data;
    logic unused;
    assign adr       = wb_adr_i[3:2];
    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign abort     = cs_rise | ~enable_q;
    assign load_byte = tx_empty_q ? DEFAULT_TX : tx_q;
    assign tx_load   = (state_q == S_IDLE) ? (cs_fall & enable_q) : (~abort & sck_fall & bitcnt_q == 3'd0);
    assign rx_byte   = {rx_sh_q[6:0], mosi_q[1]};
    assign rx_push   = (state_q == S_ACTIVE) & ~abort & sck_rise & bitcnt_q == 3'd7;
    assign wb_hit    = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr        = wb_hit & wb_we_i;
    assign rd        = wb_hit & ~wb_we_i;
    assign rx_pop    = rd & adr == REG_RXDATA;
    assign overflow  = rx_push & rx_full & ~rx_pop;
    assign status    = {~cs_q[2], overrun_q, tx_empty_q, rx_full, ~rx_empty};
    assign rd_data   = adr == REG_STATUS ? {27'd0, status} :
                       adr == REG_RXDATA ? {24'd0, rx_empty ? 8'd0 : rx_head} :
                       adr == REG_CTRL   ? {30'd0, irq_en, enable_q} : 32'd0;
    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], tx_sh_q[7], rx_sh_q[7]};

    wb_spi_slave_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rx_pop), .data_i(rx_byte),
        .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    // two-stage synchronisers plus a third stage for edge detection; cs_n idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q  <= 3'b000;
            mosi_q <= 3'b000;
            cs_q   <= 3'b111;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck};
            mosi_q <= {mosi_q[1:0], spi_mosi};
            cs_q   <= {cs_q[1:0], spi_cs_n};
        end
    end

    // frame FSM: sample on sck rise, shift out on sck fall, reload tx after each full byte
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 3'd0;
            tx_sh_q  <= 8'd0;
            rx_sh_q  <= 8'd0;
            miso_q   <= 1'b1;
            oe_q     <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (tx_load) begin
                state_q  <= S_ACTIVE;
                tx_sh_q  <= load_byte;
                miso_q   <= load_byte[7];
                oe_q     <= 1'b1;
                bitcnt_q <= 3'd0;
            end
        end else if (abort) begin
            state_q  <= S_IDLE;
            miso_q   <= 1'b1;
            oe_q     <= 1'b0;
            bitcnt_q <= 3'd0;
        end else if (sck_rise) begin
            rx_sh_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 3'd1;
        end else if (sck_fall) begin
            tx_sh_q <= tx_load ? load_byte : {tx_sh_q[6:0], 1'b0};
            miso_q  <= tx_load ? load_byte[7] : tx_sh_q[6];
        end
    end

    // wishbone register file; a TXDATA write on a load cycle lands after the load
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            tx_q       <= 8'd0;
            tx_empty_q <= 1'b1;
            overrun_q  <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            ack_q <= wb_hit;
            dat_q <= rd ? rd_data : 32'd0;
            if (tx_load) tx_empty_q <= 1'b1;
            if (wr && adr == REG_TXDATA) begin
                tx_q       <= wb_dat_i[7:0];
                tx_empty_q <= 1'b0;
            end
            if (wr && adr == REG_STATUS && wb_dat_i[ST_OVERRUN]) overrun_q <= 1'b0;
            if (overflow) overrun_q <= 1'b1;
            if (wr && adr == REG_CTRL) enable_q <= wb_dat_i[CTRL_ENABLE];
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_en_q, intr_q;
    assign irq_en = irq_en_q;
    assign intr   = intr_q;
    // level interrupt, registered so it trails the status by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            if (wr && adr == REG_CTRL) irq_en_q <= wb_dat_i[CTRL_IRQ_EN];
            intr_q <= irq_en_q & (~rx_empty | overrun_q);
        end
    end
`else
    assign irq_en = 1'b0;
    assign intr   = 1'b0;
`endif
endmodule

// File: tb/tb_wb_spi_slave.sv
// tb_wb_spi_slave: scoreboard bench for wb_spi_slave, WB reads and MISO bytes checked by monitors
module tb_wb_spi_slave;
    localparam logic [1:0] STATUS = 2'd0, RXD = 2'd1, TXD = 2'd2, CTRL = 2'd3;
    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic [3:0] wb_sel_i = 4'hF;
    logic wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1, spi_miso, spi_miso_oe, intr;
    int checks = 0, errors = 0;
    logic [31:0] exp_rd_q [$];
    logic [7:0] exp_miso_q [$];
    logic ack_prev = 1'b0;
    logic [7:0] miso_sh = 8'd0;
    int miso_n = 0;

    wb_spi_slave dut (
        .clk(clk), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_ack_o(wb_ack_o), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // WB read monitor: every read ack pops the next expected word
    always @(negedge clk) begin
        if (wb_ack_o) begin
            check("ack_single_cycle", {31'd0, ack_prev}, 32'd0);
            if (!wb_we_i) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_read: unexpected read data 0x%08h", wb_dat_o);
                end else check("wb_read", wb_dat_o, exp_rd_q.pop_front());
            end
        end
        ack_prev = wb_ack_o;
    end

    // MISO monitor: master samples on sck rise, partial frames are dropped at cs_n rise
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) miso_n = 0;
        else begin
            miso_sh = {miso_sh[6:0], spi_miso};
            miso_n++;
            if (miso_n == 8) begin
                miso_n = 0;
                if (exp_miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_byte: unexpected byte 0x%02h", miso_sh);
                end else check("miso_byte", 32'(miso_sh), 32'(exp_miso_q.pop_front()));
            end
        end
    end

    task automatic wb_xfer(input logic [1:0] ra, input logic [31:0] d, input logic we);
        bit got;
        got = 1'b0;
        @(negedge clk);
        wb_adr_i = {28'd0, ra, 2'b00};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        for (int n = 0; n < 16 && !got; n++) begin
            @(posedge clk);
            #1 got = wb_ack_o;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wb_timeout: got no ack required ack");
        end
        @(posedge clk);
        #1;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] ra, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        wb_xfer(ra, 32'd0, 1'b0);
    endtask

    task automatic wb_write(input logic [1:0] ra, input logic [31:0] d);
        wb_xfer(ra, d, 1'b1);
    endtask

    // n bits MSB first, half period 8 clk; coinc lines an RXDATA read up with the 8th-rise push
    task automatic spi_bits(input logic [7:0] b, input int n, input bit coinc, input logic [31:0] cexp);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            spi_mosi = b[i];
            repeat (7) @(negedge clk);
            spi_sck = 1'b1;
            if (coinc && i == 0) begin
                @(negedge clk);
                wb_read(RXD, cexp);
                repeat (5) @(negedge clk);
            end else repeat (8) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_miso", {31'd0, spi_miso}, 32'd1);
        check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rst_intr", {31'd0, intr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wb_read(STATUS, 32'h4);
        wb_read(CTRL, 32'h0);
        wb_write(CTRL, 32'h3);
`ifdef SPI_SLAVE_IRQ_EN
        wb_read(CTRL, 32'h3);
`else
        wb_read(CTRL, 32'h1);
`endif
        // basic exchange with loaded TX byte
        wb_write(TXD, 32'hA5);
        wb_read(STATUS, 32'h0);
        exp_miso_q.push_back(8'hA5);
        cs_low();
        check("oe_active", {31'd0, spi_miso_oe}, 32'd1);
        spi_bits(8'h3C, 8, 1'b0, 32'd0);
        cs_high();
`ifdef SPI_SLAVE_IRQ_EN
        check("intr_set", {31'd0, intr}, 32'd1);
`else
        check("intr_tied", {31'd0, intr}, 32'd0);
`endif
        wb_read(STATUS, 32'h5);
        wb_read(RXD, 32'h3C);
        wb_read(STATUS, 32'h4);
        check("intr_clear", {31'd0, intr}, 32'd0);
        check("idle_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("idle_miso", {31'd0, spi_miso}, 32'd1);
        // underrun returns DEFAULT_TX
        exp_miso_q.push_back(8'hFF);
        cs_low();
        spi_bits(8'h55, 8, 1'b0, 32'd0);
        cs_high();
        wb_read(RXD, 32'h55);
        // 17 bytes into a 16-deep FIFO
        cs_low();
        for (int k = 0; k < 17; k++) begin
            exp_miso_q.push_back(8'hFF);
            spi_bits(8'h10 + 8'(k), 8, 1'b0, 32'd0);
        end
        cs_high();
        wb_read(STATUS, 32'hF);
        for (int k = 0; k < 16; k++) wb_read(RXD, 32'h10 + 32'(k));
        wb_read(STATUS, 32'hC);
        wb_write(STATUS, 32'h8);
        wb_read(STATUS, 32'h4);
        // aborted partial frame then a clean one
        cs_low();
        spi_bits(8'hC3, 5, 1'b0, 32'd0);
        cs_high();
        wb_read(STATUS, 32'h4);
        exp_miso_q.push_back(8'hFF);
        cs_low();
        spi_bits(8'h81, 8, 1'b0, 32'd0);
        cs_high();
        wb_read(RXD, 32'h81);
        // empty read, TX overwrite, pop coincident with push
        wb_read(RXD, 32'h0);
        wb_read(STATUS, 32'h4);
        wb_write(TXD, 32'h12);
        wb_write(TXD, 32'h34);
        exp_miso_q.push_back(8'h34);
        exp_miso_q.push_back(8'hFF);
        cs_low();
        spi_bits(8'h11, 8, 1'b0, 32'd0);
        spi_bits(8'h22, 8, 1'b1, 32'h11);
        cs_high();
        wb_read(RXD, 32'h22);
        wb_read(STATUS, 32'h4);
        // clearing enable mid-frame drops back to idle
        cs_low();
        spi_bits(8'hAA, 3, 1'b0, 32'd0);
        wb_write(CTRL, 32'h0);
        repeat (2) @(negedge clk);
        check("disable_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("disable_miso", {31'd0, spi_miso}, 32'd1);
        cs_high();
        wb_read(STATUS, 32'h4);
        // reset in the middle of a frame
        wb_write(CTRL, 32'h3);
        wb_write(TXD, 32'h77);
        cs_low();
        spi_bits(8'h77, 3, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_miso", {31'd0, spi_miso}, 32'd1);
        check("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("mid_rst_intr", {31'd0, intr}, 32'd0);
        check("mid_rst_ack", {31'd0, wb_ack_o}, 32'd0);
        cs_high();
        wb_read(STATUS, 32'h4);
        wb_read(CTRL, 32'h0);
        wb_read(RXD, 32'h0);
        repeat (4) @(negedge clk);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
